// File: rtl/fifo_pkt_writer.sv
// Packet admission stage in front of an async FIFO write port.
// Ports: s_* upstream stream in, fifo_* write port out, pkt/ovs counters, ovf_err.
module fifo_pkt_writer #(
  parameter int DW      = 8,
  parameter int AW      = 7,
  parameter int PKT_MAX = 16
) (
  input  logic          rst_n,
  input  logic          wr_clk,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          fifo_wr_en,
  output logic [DW:0]   fifo_wr_data,
  input  logic          fifo_full,
  input  logic [AW:0]   fifo_wr_data_cnt,
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   ovs_cnt,
  output logic          ovf_err
);

  localparam int WW = $clog2(PKT_MAX);
  localparam logic [AW+1:0] DEPTH = (AW+2)'(2**AW);
  localparam logic [AW+1:0] NEED  = (AW+2)'(PKT_MAX+2);
  localparam logic [WW-1:0] WMAX  = WW'(PKT_MAX-1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state, nstate;

  logic [WW-1:0] wcnt;
  logic [AW+1:0] room;
  logic space_ok;
  logic hs;
  logic at_max;
  logic wr;
  logic eop;

  // Margin of 2 covers the write register and the
  // FIFO's lagging occupancy view.
  assign room     = DEPTH - {1'b0, fifo_wr_data_cnt};
  assign space_ok = room >= NEED;

  assign s_ready = (state == STREAM) || (state == DRAIN);
  assign hs      = s_valid && s_ready;
  assign at_max  = wcnt == WMAX;
  assign wr      = (state == STREAM) && hs;
  assign eop     = s_last || at_max;

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (s_valid && space_ok)
          nstate = STREAM;
      STREAM:
        if (hs && eop)
          nstate = s_last ? IDLE : DRAIN;
      DRAIN:
        if (hs && s_last)
          nstate = IDLE;
      default:
        nstate = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      wcnt         <= '0;
      pkt_cnt      <= '0;
      ovs_cnt      <= '0;
      ovf_err      <= 1'b0;
    end else begin
      state      <= nstate;
      fifo_wr_en <= wr;
      ovf_err    <= ovf_err | (fifo_wr_en & fifo_full);
      if (wr) begin
        fifo_wr_data <= {eop, s_data};
        wcnt <= eop ? '0 : wcnt + WW'(1);
        if (eop)
          pkt_cnt <= pkt_cnt + 16'd1;
        // Truncation: word PKT_MAX without s_last.
        if (at_max && !s_last)
          ovs_cnt <= ovs_cnt + 16'd1;
      end
    end
  end

endmodule
